// File: rtl/rv32i_wb_arbiter_if.sv
// Writeback arbiter bus: the two producer handshakes, the issue-stage
// scoreboard query, and the register file write port.
interface rv32i_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [4:0]            alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [4:0]            lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  issue_valid;
    logic [4:0]            issue_rd;
    logic [4:0]            rs1_reg;
    logic [4:0]            rs2_reg;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  wb_enable;
    logic [4:0]            wb_reg;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_err;

    // Producers / issue stage side
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1_reg, rs2_reg,
        input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
        input  wb_enable, wb_reg, wb_data, wb_err
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, rs1_reg, rs2_reg,
        output alu_ready, lsu_ready, rs1_busy, rs2_busy,
        output wb_enable, wb_reg, wb_data, wb_err
    );
endinterface

// File: rtl/rv32i_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and the LSU, with a pending-write scoreboard for RAW hazard stalls.
module rv32i_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int INIT_PRIO  = 0
) (
    input  logic                clk,
    input  logic                reset,
    rv32i_wb_arbiter_if.slave   bus
);
    localparam logic INIT_PRIO_L = (INIT_PRIO != 0);

    // prio_q: 0 = ALU preferred on contention, 1 = LSU preferred
    logic                  prio_q, prio_d;
    // bit 0 (x0) is never set so busy lookups of x0 read 0
    logic [31:0]           pending_q, pending_d;
    logic                  wb_enable_q, wb_enable_d;
    logic [4:0]            wb_reg_q, wb_reg_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  wb_err_q, wb_err_d;

    logic                  grant_alu_s, grant_lsu_s;
    logic [4:0]            acc_rd_s;
    logic [DATA_WIDTH-1:0] acc_data_s;
    logic                  acc_pending_s;

    // Grant selection and round-robin pointer update
    always_comb begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
        prio_d      = prio_q;
        if (bus.alu_valid && bus.lsu_valid) begin
            if (prio_q) begin
                grant_lsu_s = 1'b1;
            end else begin
                grant_alu_s = 1'b1;
            end
            // point at the loser: ALU won -> LSU preferred next
            prio_d = grant_alu_s;
        end else if (bus.alu_valid) begin
            grant_alu_s = 1'b1;
        end else if (bus.lsu_valid) begin
            grant_lsu_s = 1'b1;
        end else begin
            grant_alu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    // Accepted result mux, writeback next state and error detection
    always_comb begin
        acc_rd_s    = bus.alu_rd;
        acc_data_s  = bus.alu_data;
        if (grant_lsu_s) begin
            acc_rd_s   = bus.lsu_rd;
            acc_data_s = bus.lsu_data;
        end else begin
            acc_rd_s   = bus.alu_rd;
            acc_data_s = bus.alu_data;
        end
        // a same-cycle issue of this rd counts as pending
        acc_pending_s = pending_q[acc_rd_s] |
                        (bus.issue_valid && (bus.issue_rd == acc_rd_s));
        // x0 results are accepted but never written
        wb_enable_d = (grant_alu_s || grant_lsu_s) && (acc_rd_s != 5'd0);
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        if (wb_enable_d) begin
            wb_reg_d  = acc_rd_s;
            wb_data_d = acc_data_s;
        end else begin
            wb_reg_d  = wb_reg_q;
            wb_data_d = wb_data_q;
        end
        wb_err_d = wb_err_q | (wb_enable_d & ~acc_pending_s);
    end

    // Scoreboard next state: clear on retire, then set on issue so set wins
    always_comb begin
        pending_d = pending_q;
        if (wb_enable_q) begin
            pending_d[wb_reg_q] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; async reset drops any accepted-but-unwritten result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q      <= INIT_PRIO_L;
            pending_q   <= 32'd0;
            wb_enable_q <= 1'b0;
            wb_reg_q    <= 5'd0;
            wb_data_q   <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            pending_q   <= pending_d;
            wb_enable_q <= wb_enable_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            wb_err_q    <= wb_err_d;
        end
    end

    // Handshake readies and busy lookups are combinational
    assign bus.alu_ready = grant_alu_s;
    assign bus.lsu_ready = grant_lsu_s;
    assign bus.rs1_busy  = pending_q[bus.rs1_reg];
    assign bus.rs2_busy  = pending_q[bus.rs2_reg];
    assign bus.wb_enable = wb_enable_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Self-checking bench for rv32i_wb_arbiter: grant vector table, a per-cycle
// reference model with a writeback scoreboard queue, and directed sequences.
module tb_rv32i_wb_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    rv32i_wb_arbiter_if #(.DATA_WIDTH(32)) bus ();

    rv32i_wb_arbiter #(.DATA_WIDTH(32), .INIT_PRIO(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic       lv;
        logic [4:0] rd;
        logic       exp_ar;
        logic       exp_lr;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    vec_t    vecs [10];
    wb_exp_t sbq [$];

    // reference model state
    logic        m_prio;
    logic [31:0] m_pend;
    logic        m_err;
    wb_exp_t     m_cur;
    wb_exp_t     m_nxt;
    logic        m_ar, m_lr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = 32'd0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = 5'd0;
        bus.lsu_data    = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.rs1_reg     = 5'd0;
        bus.rs2_reg     = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    // Per-cycle model: check readies/busy/err, pop expected writeback, push next
    always @(negedge clk) begin
        if (!reset) begin
            m_prio = 1'b0;
            m_pend = 32'd0;
            m_err  = 1'b0;
            sbq.delete();
            m_nxt = '{en: 1'b0, rd: 5'd0, data: 32'd0};
            sbq.push_back(m_nxt);
        end else begin
            m_ar = bus.alu_valid && (!bus.lsu_valid || !m_prio);
            m_lr = bus.lsu_valid && (!bus.alu_valid || m_prio);
            chk("mdl_alu_ready", {31'd0, bus.alu_ready}, {31'd0, m_ar});
            chk("mdl_lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, m_lr});
            chk("mdl_rs1_busy", {31'd0, bus.rs1_busy},
                {31'd0, (bus.rs1_reg != 5'd0) && m_pend[bus.rs1_reg]});
            chk("mdl_rs2_busy", {31'd0, bus.rs2_busy},
                {31'd0, (bus.rs2_reg != 5'd0) && m_pend[bus.rs2_reg]});
            chk("mdl_wb_err", {31'd0, bus.wb_err}, {31'd0, m_err});
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
                m_cur = '{en: 1'b0, rd: 5'd0, data: 32'd0};
            end else begin
                m_cur = sbq.pop_front();
            end
            chk("sb_wb_enable", {31'd0, bus.wb_enable}, {31'd0, m_cur.en});
            if (m_cur.en) begin
                chk("sb_wb_reg", {27'd0, bus.wb_reg}, {27'd0, m_cur.rd});
                chk("sb_wb_data", bus.wb_data, m_cur.data);
            end
            m_rd   = m_lr ? bus.lsu_rd : bus.alu_rd;
            m_data = m_lr ? bus.lsu_data : bus.alu_data;
            if ((m_ar || m_lr) && (m_rd != 5'd0) &&
                !(m_pend[m_rd] || (bus.issue_valid && bus.issue_rd == m_rd)))
                m_err = 1'b1;
            if (m_cur.en) m_pend[m_cur.rd] = 1'b0;
            if (bus.issue_valid && bus.issue_rd != 5'd0) m_pend[bus.issue_rd] = 1'b1;
            if (bus.alu_valid && bus.lsu_valid) m_prio = m_ar;
            m_nxt = '{en: (m_ar || m_lr) && (m_rd != 5'd0), rd: m_rd, data: m_data};
            sbq.push_back(m_nxt);
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ai;
        int li;
        checks   = 0;
        failures = 0;
        idle();
        reset = 1'b0;
        // grant table from prio=0; every row issues rd so results are legal
        vecs[0] = '{av: 1'b0, lv: 1'b0, rd: 5'd16, exp_ar: 1'b0, exp_lr: 1'b0};
        vecs[1] = '{av: 1'b1, lv: 1'b0, rd: 5'd17, exp_ar: 1'b1, exp_lr: 1'b0};
        vecs[2] = '{av: 1'b0, lv: 1'b1, rd: 5'd18, exp_ar: 1'b0, exp_lr: 1'b1};
        vecs[3] = '{av: 1'b1, lv: 1'b1, rd: 5'd19, exp_ar: 1'b1, exp_lr: 1'b0};
        vecs[4] = '{av: 1'b1, lv: 1'b1, rd: 5'd20, exp_ar: 1'b0, exp_lr: 1'b1};
        vecs[5] = '{av: 1'b1, lv: 1'b1, rd: 5'd21, exp_ar: 1'b1, exp_lr: 1'b0};
        vecs[6] = '{av: 1'b1, lv: 1'b0, rd: 5'd22, exp_ar: 1'b1, exp_lr: 1'b0};
        vecs[7] = '{av: 1'b1, lv: 1'b1, rd: 5'd23, exp_ar: 1'b0, exp_lr: 1'b1};
        vecs[8] = '{av: 1'b0, lv: 1'b1, rd: 5'd24, exp_ar: 1'b0, exp_lr: 1'b1};
        vecs[9] = '{av: 1'b1, lv: 1'b1, rd: 5'd25, exp_ar: 1'b1, exp_lr: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_enable", {31'd0, bus.wb_enable}, 32'd0);
        chk("rst_wb_reg", {27'd0, bus.wb_reg}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
        next_cycle();
        reset = 1'b1;

        // single ALU write
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs1_reg = 5'd5;
        @(negedge clk);
        chk("alu1_busy_pre", {31'd0, bus.rs1_busy}, 32'd0);
        next_cycle();
        bus.issue_valid = 1'b0; bus.alu_valid = 1'b1; bus.alu_rd = 5'd5;
        bus.alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("alu1_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("alu1_busy_acc", {31'd0, bus.rs1_busy}, 32'd1);
        next_cycle();
        bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("alu1_wb_enable", {31'd0, bus.wb_enable}, 32'd1);
        chk("alu1_wb_reg", {27'd0, bus.wb_reg}, 32'd5);
        chk("alu1_wb_data", bus.wb_data, 32'hDEADBEEF);
        chk("alu1_busy_wb", {31'd0, bus.rs1_busy}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("alu1_wb_done", {31'd0, bus.wb_enable}, 32'd0);
        chk("alu1_busy_post", {31'd0, bus.rs1_busy}, 32'd0);
        next_cycle();

        // grant table
        for (int i = 0; i < 10; i++) begin
            bus.alu_valid = vecs[i].av; bus.lsu_valid = vecs[i].lv;
            bus.alu_rd = vecs[i].rd; bus.lsu_rd = vecs[i].rd;
            bus.alu_data = 32'hA000_0000 + i; bus.lsu_data = 32'hB000_0000 + i;
            bus.issue_valid = 1'b1; bus.issue_rd = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, vecs[i].exp_ar});
            chk($sformatf("vec%0d_lsu_ready", i), {31'd0, bus.lsu_ready}, {31'd0, vecs[i].exp_lr});
            next_cycle();
        end
        idle();
        next_cycle();

        // contention: ALU then LSU, writebacks back to back
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        next_cycle();
        bus.issue_rd = 5'd4;
        next_cycle();
        bus.issue_rd = 5'd7;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h22;
        @(negedge clk);
        chk("cont_n_alu", {31'd0, bus.alu_ready}, 32'd1);
        chk("cont_n_lsu", {31'd0, bus.lsu_ready}, 32'd0);
        next_cycle();
        bus.issue_valid = 1'b0; bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("cont_n1_lsu", {31'd0, bus.lsu_ready}, 32'd1);
        chk("cont_wb1_reg", {27'd0, bus.wb_reg}, 32'd3);
        chk("cont_wb1_data", bus.wb_data, 32'h11);
        next_cycle();
        bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
        @(negedge clk);
        chk("cont_n2_lsu", {31'd0, bus.lsu_ready}, 32'd1);
        chk("cont_wb2_reg", {27'd0, bus.wb_reg}, 32'd4);
        chk("cont_wb2_data", bus.wb_data, 32'h22);
        next_cycle();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        chk("cont_wb3_en", {31'd0, bus.wb_enable}, 32'd1);
        chk("cont_wb3_reg", {27'd0, bus.wb_reg}, 32'd7);
        chk("cont_err", {31'd0, bus.wb_err}, 32'd0);
        next_cycle();

        // x0 write then unexpected write to x9
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5;
        @(negedge clk);
        chk("x0_ready", {31'd0, bus.alu_ready}, 32'd1);
        next_cycle();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
        @(negedge clk);
        chk("x0_wb_enable", {31'd0, bus.wb_enable}, 32'd0);
        chk("x0_err", {31'd0, bus.wb_err}, 32'd0);
        chk("x9_ready", {31'd0, bus.lsu_ready}, 32'd1);
        next_cycle();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        chk("x9_err", {31'd0, bus.wb_err}, 32'd1);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("x9_err_sticky", {31'd0, bus.wb_err}, 32'd1);
        next_cycle();

        // mid-stream reset with a result in flight and prio pointing at LSU
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd20;
        next_cycle();
        bus.issue_rd = 5'd21;
        next_cycle();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h2020;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd21; bus.lsu_data = 32'h2121;
        next_cycle();
        bus.alu_valid = 1'b0; bus.rs1_reg = 5'd21;
        @(negedge clk);
        chk("mrst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
        chk("mrst_wb_pre", {31'd0, bus.wb_enable}, 32'd1);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("mrst_wb_enable", {31'd0, bus.wb_enable}, 32'd0);
        chk("mrst_wb_err", {31'd0, bus.wb_err}, 32'd0);
        chk("mrst_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
        idle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_dropped", {31'd0, bus.wb_enable}, 32'd0);
        next_cycle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd22;
        next_cycle();
        bus.issue_rd = 5'd23;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd22; bus.alu_data = 32'h2222;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd23; bus.lsu_data = 32'h2323;
        @(negedge clk);
        chk("mrst_prio_alu", {31'd0, bus.alu_ready}, 32'd1);
        next_cycle();
        bus.issue_valid = 1'b0; bus.alu_valid = 1'b0;
        next_cycle();
        bus.lsu_valid = 1'b0;
        next_cycle();

        // set/clear collision on x12
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
        next_cycle();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC;
        next_cycle();
        bus.alu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12; bus.rs2_reg = 5'd12;
        @(negedge clk);
        chk("coll_wb_enable", {31'd0, bus.wb_enable}, 32'd1);
        chk("coll_wb_reg", {27'd0, bus.wb_reg}, 32'd12);
        next_cycle();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("coll_rs2_busy", {31'd0, bus.rs2_busy}, 32'd1);
        next_cycle();

        // six cycles of continuous contention alternate grants
        do_reset();
        for (int r = 10; r < 16; r++) begin
            bus.issue_valid = 1'b1; bus.issue_rd = r[4:0];
            next_cycle();
        end
        bus.issue_valid = 1'b0;
        ai = 0;
        li = 0;
        for (int k = 0; k < 6; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + 2 * ai);
            bus.alu_data = 32'hA100 + ai;
            bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(11 + 2 * li);
            bus.lsu_data = 32'hB100 + li;
            @(negedge clk);
            chk($sformatf("rr%0d_alu_ready", k), {31'd0, bus.alu_ready}, {31'd0, (k % 2) == 0});
            chk($sformatf("rr%0d_lsu_ready", k), {31'd0, bus.lsu_ready}, {31'd0, (k % 2) == 1});
            if ((k % 2) == 0) ai++;
            else li++;
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32i_wb_arbiter.md
Name: rv32i_wb_arbiter

Overview:
- Shares the register file's single write port between two result producers: ALU and load/store unit (LSU).
- Arbitrates round-robin and registers the winner onto wb_enable/wb_reg/wb_data, which feed the register file write port directly.
- Keeps a pending-write scoreboard for x1..x31 so the issue stage can stall on read-after-write hazards against rs1/rs2.

Parameters:
- DATA_WIDTH, 32, width of writeback data.
- INIT_PRIO, 0, round-robin pointer value after reset (0 = ALU preferred, 1 = LSU preferred).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU has a result.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  LSU has load data.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  DATA_WIDTH  load data.
- issue_valid  in  1  instruction issued this cycle that will write issue_rd.
- issue_rd  in  5  destination of the issued instruction.
- rs1_reg  in  5  source register 1 queried by issue.
- rs2_reg  in  5  source register 2 queried by issue.
- rs1_busy  out  1  rs1_reg has a write outstanding.
- rs2_busy  out  1  rs2_reg has a write outstanding.
- wb_enable  out  1  register file write enable.
- wb_reg  out  5  register file write address.
- wb_data  out  DATA_WIDTH  register file write data.
- wb_err  out  1  sticky: writeback seen to a register not pending.

Behaviour:
- Reset (reset=0, async):
  - wb_enable=0, wb_reg=0, wb_data=0, wb_err=0.
  - All pending bits 0; prio=INIT_PRIO.
  - Reset mid-transfer discards any accepted-but-unwritten result.
- Handshake:
  - Transfer occurs when valid & ready.
  - ready is combinational from the valids and prio; at most one ready per cycle.
  - Producers hold valid/rd/data stable until ready.
- Grant:
  - Only one valid: that requester gets ready=1.
  - Both valid: prio=0 grants ALU, prio=1 grants LSU.
  - After any contended grant (both valid), prio is set to point at the loser.
  - Uncontended grants leave prio unchanged.
  - Neither valid: both ready=0.
- Writeback, latency 1:
  - Transfer in cycle N gives wb_enable=1 with that rd/data in cycle N+1.
  - No transfer in cycle N gives wb_enable=0 in N+1; wb_reg/wb_data hold their last values.
  - The write port never back-pressures, so one result retires per cycle at full throughput.
- x0 handling:
  - A granted request with rd=0 is accepted (ready=1) but produces wb_enable=0.
  - It is not checked against the scoreboard.
- Scoreboard, pending[31:1]:
  - Set: issue_valid=1 and issue_rd!=0.
  - Clear: on the edge ending a cycle with wb_enable=1, clear pending[wb_reg].
  - Same register set and cleared on the same edge: set wins (new producer).
  - Issue of an already-pending rd: bit stays set, no error.
- Busy outputs:
  - rs1_busy=pending[rs1_reg], rs2_busy=pending[rs2_reg], combinational; x0 always 0.
  - During the wb_enable cycle, busy is still 1, because the register file captures data only on that edge.
- wb_err:
  - Set when a transfer is accepted with rd!=0 and pending[rd]=0.
  - pending[rd] is evaluated including the same-cycle issue set.
  - Cleared only by reset.

Test Plan:
- Reset: assert reset=0 mid-stream -> wb_enable=0, wb_err=0, rs1_busy=rs2_busy=0 immediately; prio=INIT_PRIO after release.
- Single ALU write: issue_valid with rd=5, next cycle alu_valid rd=5 data=0xDEADBEEF.
  - alu_ready=1; one cycle later wb_enable=1, wb_reg=5, wb_data=0xDEADBEEF.
  - rs1_reg=5 gives rs1_busy=1 through that cycle and 0 the cycle after.
- Contention: issue rd=3 and rd=4; both valid (ALU rd=3/0x11, LSU rd=4/0x22), LSU also pending rd=7 next.
  - Cycle N: ALU granted.
  - Cycle N+1: LSU granted.
  - Writebacks appear on consecutive cycles in that order, one per cycle.
- Continuous contention for 6 cycles: grants alternate ALU, LSU, ALU, LSU, ALU, LSU; neither side waits more than one cycle.
- x0 and error cases:
  - ALU rd=0 is accepted with wb_enable=0 and wb_err stays 0.
  - LSU rd=9 with pending[9]=0 gives wb_err=1, which persists until reset.
- Set/clear collision: pending rd=12 is written back (wb_enable=1, wb_reg=12) in the same cycle issue_valid rd=12 -> next cycle rs2_reg=12 gives rs2_busy=1.
